// File: rtl/nibble_serial_adder_pkg.sv
// ---------------------------------------------------------------------------
// nibble_serial_adder_pkg
// Shared definitions for the nibble-serial adder: the controller state
// encoding and the width of one serial digit (a nibble).
// ---------------------------------------------------------------------------
package nibble_serial_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/nibble_serial_adder_if.sv
// ---------------------------------------------------------------------------
// nibble_serial_adder_if
// Operand/result handshake bundle for the nibble-serial adder.
//   in_valid/in_ready   : operand offer / acceptance (a, b, cin)
//   out_valid/out_ready : result offer / consumption (sum, cout, ovf)
// Modports:
//   master : producer of operands and consumer of results (e.g. a bench)
//   slave  : the adder itself
// ---------------------------------------------------------------------------
import nibble_serial_adder_pkg::*;

interface nibble_serial_adder_if #(
  parameter int NIBBLES = 4
);
  localparam int W = NIBBLE_W * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/RCA.sv
// ---------------------------------------------------------------------------
// RCA
// 4-bit ripple-carry adder built from a chain of full adders.
//   s    : 4-bit sum
//   cout : carry out of bit 3
//   a, b : 4-bit addends
//   ci   : carry into bit 0
// ---------------------------------------------------------------------------
module RCA (
  output logic [3:0] s,
  output logic       cout,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci
);

  logic [4:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// ---------------------------------------------------------------------------
// nibble_serial_adder
// Adds two W-bit operands (W = 4*NIBBLES) plus a carry-in one nibble per
// clock using a single 4-bit ripple-carry adder. Operands are captured on
// the accept edge; the result is held until the consumer takes it.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of nibble_serial_adder_if
//           (in_valid/in_ready/a/b/cin in, out_valid/out_ready/sum/cout/ovf out)
// ---------------------------------------------------------------------------
import nibble_serial_adder_pkg::*;

module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  nibble_serial_adder_if.slave  bus
);

  localparam int                 W     = NIBBLE_W * NIBBLES;
  localparam int                 IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0]   LAST  = IDX_W'(NIBBLES - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q,   idx_d;
  logic [W-1:0]       a_q,     a_d;
  logic [W-1:0]       b_q,     b_d;
  logic [W-1:0]       sum_q,   sum_d;
  logic               carry_q, carry_d;
  logic               cout_q,  cout_d;
  logic               ovf_q,   ovf_d;

  logic [NIBBLE_W-1:0] a_nib;
  logic [NIBBLE_W-1:0] b_nib;
  logic [NIBBLE_W-1:0] nib_s;
  logic                nib_co;

  // Select the nibble currently being processed from the captured operands.
  assign a_nib = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
  assign b_nib = b_q[idx_q*NIBBLE_W +: NIBBLE_W];

  RCA u_rca (nib_s, nib_co, a_nib, b_nib, carry_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.cin;
          idx_d   = '0;
          state_d = CALC;
        end
      end

      CALC: begin
        sum_d[idx_q*NIBBLE_W +: NIBBLE_W] = nib_s;
        carry_d = nib_co;
        if (idx_q == LAST) begin
          state_d = DONE;
          cout_d  = nib_co;
          // Top sum bit is nib_s[3] on this edge; it is not in sum_q yet.
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (nib_s[NIBBLE_W-1] != a_q[W-1]);
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, number of 4-bit nibbles per operand; operand width W = 4*NIBBLES; legal range 2..8.
REQ-002 SHALL use one clock; reset is asynchronous and active-low; ports named clk and rst_n.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  operands a, b, cin offered.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 a  input  W  addend A, unsigned or two's complement.
REQ-008 b  input  W  addend B.
REQ-009 cin  input  1  carry into nibble 0.
REQ-010 out_valid  output  1  result held on sum/cout/ovf.
REQ-011 out_ready  input  1  consumer takes result.
REQ-012 sum  output  W  registered A+B+cin modulo 2^W.
REQ-013 cout  output  1  carry out of bit W-1.
REQ-014 ovf  output  1  signed overflow flag.

Function
REQ-015 SHALL implement FSM states IDLE, CALC, DONE; reset state IDLE.
REQ-016 in_ready SHALL be 1 exactly in IDLE; out_valid SHALL be 1 exactly in DONE.
REQ-017 Accept occurs on a rising clk edge with in_valid=1 and in_ready=1; a, b, cin SHALL be captured into internal registers at that edge, nibble index set to 0, state -> CALC.
REQ-018 Operand inputs SHALL be ignored outside the accept edge; changes during CALC/DONE have no effect.
REQ-019 In CALC, each cycle SHALL add captured nibble k of A and B plus the carry register via one 4-bit ripple-carry adder; the edge ending the cycle writes result into sum[4k+3:4k] and the adder carry-out into the carry register; carry register initialised from cin at accept.
REQ-020 Nibble index SHALL increment 0..NIBBLES-1; on the edge that processes nibble NIBBLES-1, state -> DONE, cout <- final carry.
REQ-021 Latency: out_valid SHALL rise exactly NIBBLES clock edges after the accept edge (4 for default).
REQ-022 ovf SHALL equal (A[W-1]==B[W-1]) and (sum[W-1]!=A[W-1]), registered with cout on the final CALC edge.
REQ-023 In DONE, sum, cout, ovf SHALL stay stable until out_ready=1; on that edge state -> IDLE; no throughput overlap (one operation per NIBBLES+2 cycles minimum).
REQ-024 out_ready SHALL be ignored outside DONE; in_valid SHALL be ignored outside IDLE.
REQ-025 sum bits of nibbles not yet processed in CALC are don't-care; out_valid is 0 then.
REQ-026 Wrap-around: carry out of bit W-1 SHALL appear only on cout, never wrap into nibble 0.

Reset
REQ-027 rst_n=0 SHALL asynchronously force state IDLE, sum=0, cout=0, ovf=0, carry register=0, nibble index=0, captured operands=0; thus in_ready=1, out_valid=0.
REQ-028 Reset asserted mid-CALC or in DONE SHALL abort the operation; no result is delivered after release.
REQ-029 First accept SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-030 Shared package SHALL hold FSM state enumeration (IDLE, CALC, DONE) and constant NIBBLE_W=4.
REQ-031 SHALL contain exactly one instance of the team's existing 4-bit ripple-carry adder RCA, connected positionally (s, cout, a, b, ci); no other arithmetic on data path except nibble muxing and ovf logic.
REQ-032 All outputs SHALL be driven from registers or from the state register only.

Verification
REQ-033 a=0x1234, b=0x4321, cin=0 accepted -> 4 edges later out_valid=1, sum=0x5555, cout=0, ovf=0.
REQ-034 a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0; a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1; a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
REQ-035 a=0x0000, b=0xFFFF, cin=1 -> sum=0x0000, cout=1 (carry ripples across all four nibble cycles).
REQ-036 Backpressure: hold out_ready=0 for 3 cycles in DONE -> sum/cout/ovf stable, in_ready=0; raise out_ready -> IDLE next edge, in_ready=1.
REQ-037 Change a/b/cin every cycle during CALC -> result matches operands captured at accept; pulse rst_n low during CALC nibble 2 -> out_valid=0, sum=0, in_ready=1 immediately, no result delivered.
